dmem_responder: RTL

- Memory-side responder for the pipelined core's M-stage data port. Receives MemWriteM/DataAdrM/WriteDataM/ByteEnM and returns ReadDataM.
- Contains a word-addressed data RAM, a small MMIO status window, and a store-monitor FSM.
- The FSM judges completion of the self-check program and drives done/pass/fail for the SoC top and the benches.

---
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the M-stage data port.
//
// Holds a word-addressed data RAM, a three-word read-only MMIO status
// window and a store monitor that judges the self-check program.
//
// Ports:
//   clk, reset             posedge clock, asynchronous active-high reset
//   MemWriteM              store strobe (one store per asserted cycle)
//   DataAdrM[31:0]         byte address, bits [1:0] ignored
//   WriteDataM[31:0]       store data
//   ByteEnM[3:0]           per-byte write enable
//   ReadDataM[31:0]        combinational load data
//   done / pass / fail     monitor verdict, registered
//   err_oob                sticky: a store hit an unmapped address
//
// Build option: define DMEM_MONITOR_STRICT_EN to make any store other than
// to PASS_ADDR / IGNORE_ADDR fail the monitor while it is still running.
//
// MMIO window (read-only, writes dropped):
//   +0 {30'b0, pass, done}   +4 {16'b0, store_count}   +8 cycle_count
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] PASS_ADDR   = 32'd100,
  parameter logic [31:0] PASS_VALUE  = 32'd25,
  parameter logic [31:0] IGNORE_ADDR = 32'd96,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] ReadDataM,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        err_oob
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [29:0] RAM_WORDS  = 30'(DEPTH_WORDS);
  localparam logic [29:0] MMIO_WBASE = MMIO_BASE[31:2];
  localparam logic [29:0] PASS_W     = PASS_ADDR[31:2];
  localparam logic [29:0] IGNORE_W   = IGNORE_ADDR[31:2];

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        err_oob_q, err_oob_d;
  logic [15:0] store_count_q, store_count_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  logic [31:0] ram_q [DEPTH_WORDS];
  logic [31:0] ram_wdata_d;
  logic        ram_we;

  logic [29:0]   adr_w;
  logic [29:0]   mmio_off;
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic          adr_lsb_unused;

  // Address decode works on the word address only.
  assign adr_w          = DataAdrM[31:2];
  assign adr_lsb_unused = ^DataAdrM[1:0];
  // Wrapping subtraction: addresses below the base land far above 3.
  assign mmio_off       = adr_w - MMIO_WBASE;
  assign ram_hit        = (adr_w < RAM_WORDS);
  assign mmio_hit       = (mmio_off < 30'd3);
  assign ram_idx        = DataAdrM[AW+1:2];
  assign ram_we         = MemWriteM && ram_hit;

  // Byte-merge of the store into the addressed word.
  always_comb begin
    ram_wdata_d = ram_q[ram_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (ByteEnM[i]) begin
        ram_wdata_d[8*i +: 8] = WriteDataM[8*i +: 8];
      end
    end
  end

  // Contents are never cleared; reset only blocks a store that coincides
  // with reset being asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (ram_we) begin
      ram_q[ram_idx] <= ram_wdata_d;
    end
  end

  // Combinational load path.
  always_comb begin
    ReadDataM = '0;
    if (ram_hit) begin
      ReadDataM = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off[1:0])
        2'd0:    ReadDataM = {30'b0, pass_q, done_q};
        2'd1:    ReadDataM = {16'b0, store_count_q};
        default: ReadDataM = cycle_count_q;
      endcase
    end
  end

  // Store monitor: next state and registered verdict outputs.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && MemWriteM) begin
      if (adr_w == PASS_W) begin
        if (ByteEnM == 4'hF && WriteDataM == PASS_VALUE) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_FAIL;
        end
      end else if (adr_w == IGNORE_W) begin
        state_d = ST_RUN;
      end else begin
`ifdef DMEM_MONITOR_STRICT_EN
        state_d = ST_FAIL;
`else
        state_d = ST_RUN;
`endif
      end
    end
    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
  end

  // Counters and the sticky out-of-bounds flag.
  always_comb begin
    store_count_d = store_count_q;
    if (MemWriteM && store_count_q != '1) begin
      store_count_d = store_count_q + 16'd1;
    end
    cycle_count_d = cycle_count_q;
    if (state_q == ST_RUN) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
    err_oob_d = err_oob_q | (MemWriteM & ~ram_hit & ~mmio_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      err_oob_q     <= 1'b0;
      store_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      err_oob_q     <= err_oob_d;
      store_count_q <= store_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign err_oob = err_oob_q;

endmodule
